// File: rtl/multi_chroma_key_if.sv
// multi_chroma_key_if: pixel stream bundle between HSV source, keyer and substitution mux
// master drives pix_valid/hsv_in and receives the delayed pixel with per-key and combined match;
// slave is the keyer side.
interface multi_chroma_key_if #(
   parameter int CW    = 8,
   parameter int NKEYS = 2
);
   logic             pix_valid;
   logic [3*CW-1:0]  hsv_in;
   logic [3*CW-1:0]  hsv_out;
   logic             valid_out;
   logic [NKEYS-1:0] key_match;
   logic             chroma_key_match;
   modport master (output pix_valid, hsv_in, input hsv_out, valid_out, key_match, chroma_key_match);
   modport slave (input pix_valid, hsv_in, output hsv_out, valid_out, key_match, chroma_key_match);
endinterface

// File: rtl/multi_chroma_key.sv
// multi_chroma_key: 2-stage HSV keyer against NKEYS adjustable windows with per-frame match count
// clk, rst (sync, active-low); vsync (falling edge = frame start); up/down/left/right buttons,
// adjust_thr_en, key_sel select the key slot to adjust/display; h_nom/s_nom/v_nom/range show it;
// match_count = matched valid pixels of the previous frame; pix = pixel stream (slave side).
module multi_chroma_key #(
   parameter int CW            = 8,
   parameter int NKEYS         = 2,
   parameter int ADJ_DIV       = 16,
   parameter int CNT_W         = 20,
   parameter int H_NOMINAL     = 85,
   parameter int S_NOMINAL     = 94,
   parameter int V_NOMINAL     = 202,
   parameter int RANGE_NOMINAL = 50,
   parameter int V_RANGE_POS   = 50,
   parameter int V_RANGE_NEG   = 100,
   parameter int HUE_WRAP      = 1,
   parameter int KSW           = (NKEYS > 1) ? $clog2(NKEYS) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vsync,
   input  logic             up,
   input  logic             down,
   input  logic             left,
   input  logic             right,
   input  logic             adjust_thr_en,
   input  logic [KSW-1:0]   key_sel,
   output logic [CW-1:0]    h_nom,
   output logic [CW-1:0]    s_nom,
   output logic [CW-1:0]    v_nom,
   output logic [CW-1:0]    range,
   output logic [CNT_W-1:0] match_count,
   multi_chroma_key_if.slave pix
);
   localparam logic [CW:0]      MAX  = {1'b0, {CW{1'b1}}};
   localparam logic [CW:0]      VPOS = (CW+1)'(V_RANGE_POS);
   localparam logic [CW:0]      VNEG = (CW+1)'(V_RANGE_NEG);
   localparam logic [CNT_W-1:0] CMAX = '1;
   localparam int               DW   = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
   localparam logic [DW-1:0]    DLAST = DW'(ADJ_DIV - 1);
   localparam logic [KSW:0]     NK   = (KSW+1)'(NKEYS);

   logic [CW-1:0]           hn [NKEYS];
   logic [CW-1:0]           sn [NKEYS];
   logic [CW-1:0]           vn [NKEYS];
   logic [CW-1:0]           rn [NKEYS];
   logic [CW-1:0]           h, s, v;
   logic [NKEYS-1:0][2:0]   hit_c, hit1;
   logic [NKEYS-1:0]        km_c;
   logic [3*CW-1:0]         hsv1;
   logic                    v1;
   logic                    vsync_q, vsync_fall, sel_ok, step, inc;
   logic [DW-1:0]           div;
   logic [CNT_W-1:0]        acc, acc_n;

   // Saturating window nom-neg .. nom+pos, inclusive, evaluated in CW+1 bits.
   function automatic logic in_rng(input logic [CW-1:0] x, nom, input logic [CW:0] neg, pos);
      logic [CW:0] lo, hi;
      lo = ({1'b0, nom} >= neg) ? {1'b0, nom} - neg : '0;
      hi = ({1'b0, nom} + pos > MAX) ? MAX : {1'b0, nom} + pos;
      return ({1'b0, x} >= lo) && ({1'b0, x} <= hi);
   endfunction

   // Circular hue window; when it spans the whole circle every hue matches.
   function automatic logic hue_in(input logic [CW-1:0] x, nom, r);
      logic [CW-1:0] lo, hi;
      lo = nom - r;
      hi = nom + r;
      return ({r, 1'b0} >= MAX) || ((lo <= hi) ? (x >= lo && x <= hi) : (x >= lo || x <= hi));
   endfunction

   function automatic logic [CW-1:0] nudge(input logic [CW-1:0] x, input logic inc_b, dec_b);
      return (inc_b && !dec_b) ? ((x == MAX[CW-1:0]) ? x : x + 1'b1) :
             (dec_b && !inc_b) ? ((x == '0) ? x : x - 1'b1) : x;
   endfunction

   assign h = pix.hsv_in[3*CW-1:2*CW];
   assign s = pix.hsv_in[2*CW-1:CW];
   assign v = pix.hsv_in[CW-1:0];

   always_comb begin
      hit_c = '0;
      km_c  = '0;
      for (int i = 0; i < NKEYS; i++) begin
         hit_c[i] = {(HUE_WRAP != 0) ? hue_in(h, hn[i], rn[i]) : in_rng(h, hn[i], {1'b0, rn[i]}, {1'b0, rn[i]}),
                     in_rng(s, sn[i], {1'b0, rn[i]}, {1'b0, rn[i]}),
                     in_rng(v, vn[i], VNEG, VPOS)};
         km_c[i]  = &hit1[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hsv1                 <= '0;
         v1                   <= 1'b0;
         hit1                 <= '0;
         pix.hsv_out          <= '0;
         pix.valid_out        <= 1'b0;
         pix.key_match        <= '0;
         pix.chroma_key_match <= 1'b0;
      end else begin
         hsv1                 <= pix.hsv_in;
         v1                   <= pix.pix_valid;
         hit1                 <= hit_c;
         pix.hsv_out          <= hsv1;
         pix.valid_out        <= v1;
         pix.key_match        <= v1 ? km_c : '0;
         pix.chroma_key_match <= v1 & (|km_c);
      end
   end

   assign vsync_fall = vsync_q & ~vsync;
   assign sel_ok     = {1'b0, key_sel} < NK;
   assign step       = adjust_thr_en & vsync_fall & (div == DLAST) & sel_ok;

   always_ff @(posedge clk) begin
      if (!rst) begin
         vsync_q <= 1'b0;
         div     <= '0;
         for (int i = 0; i < NKEYS; i++) begin
            hn[i] <= CW'(H_NOMINAL);
            sn[i] <= CW'(S_NOMINAL);
            vn[i] <= CW'(V_NOMINAL);
            rn[i] <= CW'(RANGE_NOMINAL);
         end
      end else begin
         vsync_q <= vsync;
         div     <= !adjust_thr_en ? '0 : vsync_fall ? ((div == DLAST) ? '0 : div + 1'b1) : div;
         for (int i = 0; i < NKEYS; i++) begin
            if (step && key_sel == KSW'(i)) begin
               if (!left && !right) hn[i] <= nudge(hn[i], up, down);
               if (left && !right)  sn[i] <= nudge(sn[i], up, down);
               if (!left && right)  vn[i] <= nudge(vn[i], up, down);
               if (left && right)   rn[i] <= nudge(rn[i], up, down);
            end
         end
      end
   end

   assign h_nom = sel_ok ? hn[key_sel] : '0;
   assign s_nom = sel_ok ? sn[key_sel] : '0;
   assign v_nom = sel_ok ? vn[key_sel] : '0;
   assign range = sel_ok ? rn[key_sel] : '0;

   // The match presented on the vsync_fall cycle still belongs to the closing frame.
   assign inc   = pix.valid_out & pix.chroma_key_match;
   assign acc_n = (acc == CMAX || !inc) ? acc : acc + 1'b1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc         <= '0;
         match_count <= '0;
      end else if (vsync_fall) begin
         match_count <= acc_n;
         acc         <= '0;
      end else begin
         acc <= acc_n;
      end
   end
endmodule

// File: tb/tb_multi_chroma_key.sv
// tb_multi_chroma_key: scoreboard bench for multi_chroma_key with directed vectors
module tb_multi_chroma_key;
   typedef struct packed {
      logic [23:0] hsv;
      logic [2:0]  km;
      logic        ck;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        vsync = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0, adj = 1'b0;
   logic [1:0]  key_sel = 2'd0;
   logic        pv = 1'b0;
   logic [23:0] hsv = '0;
   logic [7:0]  h_nom, s_nom, v_nom, range, h4, s4, v4, r4;
   logic [19:0] mc;
   logic [3:0]  mc4;
   int          pass_cnt = 0;
   int          tot_cnt = 0;
   exp_t        q[$];

   multi_chroma_key_if #(.CW(8), .NKEYS(3)) bus ();
   multi_chroma_key_if #(.CW(8), .NKEYS(3)) bus4 ();

   assign bus.pix_valid  = pv;
   assign bus.hsv_in     = hsv;
   assign bus4.pix_valid = pv;
   assign bus4.hsv_in    = hsv;

   multi_chroma_key #(.NKEYS(3)) dut (
      .clk(clk), .rst(rst), .vsync(vsync), .up(up), .down(down), .left(left), .right(right),
      .adjust_thr_en(adj), .key_sel(key_sel), .h_nom(h_nom), .s_nom(s_nom), .v_nom(v_nom),
      .range(range), .match_count(mc), .pix(bus.slave));

   multi_chroma_key #(.NKEYS(3), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .vsync(vsync), .up(up), .down(down), .left(left), .right(right),
      .adjust_thr_en(adj), .key_sel(key_sel), .h_nom(h4), .s_nom(s4), .v_nom(v4),
      .range(r4), .match_count(mc4), .pix(bus4.slave));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tot_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s got %0h want %0h", name, got, exp);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (bus.valid_out) begin
         if (q.size() == 0) begin
            tot_cnt++;
            $display("FAIL unexpected_pixel got %0h want none", bus.hsv_out);
         end else begin
            e = q.pop_front();
            chk("pixel_out", {4'd0, bus.hsv_out, bus.key_match, bus.chroma_key_match}, {4'd0, e});
         end
      end else begin
         chk("idle_match", {28'd0, bus.key_match, bus.chroma_key_match}, 32'd0);
      end
   end

   task automatic px(input logic [7:0] h, s, v, input logic [2:0] km, input logic push);
      @(negedge clk);
      pv  = 1'b1;
      hsv = {h, s, v};
      if (push) q.push_back({h, s, v, km, |km});
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pv = 1'b0;
      end
   endtask

   task automatic fall();
      @(negedge clk);
      pv    = 1'b0;
      vsync = 1'b1;
      @(negedge clk);
      vsync = 1'b0;
   endtask

   task automatic steps(input int n);
      repeat (n * 16) fall();
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
      chk("rst_hsv_out", {8'd0, bus.hsv_out}, 32'd0);
      chk("rst_match_count", {12'd0, mc}, 32'd0);
      chk("rst_h_nom", {24'd0, h_nom}, 32'd85);
      chk("rst_s_nom", {24'd0, s_nom}, 32'd94);
      chk("rst_v_nom", {24'd0, v_nom}, 32'd202);
      chk("rst_range", {24'd0, range}, 32'd50);
      rst = 1'b1;
      key_sel = 2'd3;
      @(negedge clk);
      chk("bad_sel_h_nom", {24'd0, h_nom}, 32'd0);
      chk("bad_sel_range", {24'd0, range}, 32'd0);
      key_sel = 2'd0;
      px(85, 94, 202, 3'b111, 1);
      px(35, 94, 202, 3'b111, 1);
      px(135, 94, 202, 3'b111, 1);
      px(34, 94, 202, 3'b000, 1);
      px(136, 94, 202, 3'b000, 1);
      px(85, 44, 202, 3'b111, 1);
      px(85, 144, 202, 3'b111, 1);
      px(85, 43, 202, 3'b000, 1);
      px(85, 145, 202, 3'b000, 1);
      px(85, 94, 102, 3'b111, 1);
      px(85, 94, 252, 3'b111, 1);
      px(85, 94, 101, 3'b000, 1);
      px(85, 94, 253, 3'b000, 1);
      idle(3);
      fall();
      for (int i = 0; i < 150; i++) begin
         if (i % 3 == 0) px(34, 94, 202, 3'b000, 1);
         else px(85, 94, 202, 3'b111, 1);
      end
      fall();
      @(negedge clk);
      chk("frame_count", {12'd0, mc}, 32'd100);
      chk("frame_count_sat", {28'd0, mc4}, 32'd15);
      adj = 1'b1;
      key_sel = 2'd1;
      up = 1'b1;
      steps(2);
      chk("adj_h_key1", {24'd0, h_nom}, 32'd87);
      key_sel = 2'd0;
      @(negedge clk);
      chk("adj_h_key0_same", {24'd0, h_nom}, 32'd85);
      key_sel = 2'd1;
      down = 1'b1;
      steps(1);
      chk("adj_up_down_hold", {24'd0, h_nom}, 32'd87);
      down = 1'b0;
      right = 1'b1;
      steps(60);
      chk("adj_v_sat_max", {24'd0, v_nom}, 32'd255);
      right = 1'b0;
      up = 1'b0;
      down = 1'b1;
      steps(77);
      chk("adj_h_to_10", {24'd0, h_nom}, 32'd10);
      down = 1'b0;
      px(216, 94, 202, 3'b010, 1);
      px(255, 94, 202, 3'b010, 1);
      px(0, 94, 202, 3'b010, 1);
      px(60, 94, 202, 3'b111, 1);
      px(215, 94, 202, 3'b000, 1);
      px(61, 94, 202, 3'b101, 1);
      idle(3);
      left = 1'b1;
      right = 1'b1;
      up = 1'b1;
      steps(78);
      chk("adj_range_128", {24'd0, range}, 32'd128);
      px(200, 94, 202, 3'b010, 1);
      px(61, 94, 202, 3'b111, 1);
      px(215, 94, 202, 3'b010, 1);
      idle(3);
      left = 1'b0;
      right = 1'b0;
      up = 1'b0;
      adj = 1'b0;
      fall();
      repeat (5) px(85, 94, 202, 3'b111, 1);
      px(85, 94, 202, 3'b111, 0);
      @(negedge clk);
      hsv = {8'd85, 8'd94, 8'd202};
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid_out", {31'd0, bus.valid_out}, 32'd0);
      chk("midrst_h_nom", {24'd0, h_nom}, 32'd85);
      chk("midrst_v_nom", {24'd0, v_nom}, 32'd202);
      chk("midrst_range", {24'd0, range}, 32'd50);
      rst = 1'b1;
      pv = 1'b0;
      repeat (3) px(85, 94, 202, 3'b111, 1);
      fall();
      @(negedge clk);
      chk("post_rst_count", {12'd0, mc}, 32'd3);
      chk("post_rst_count4", {28'd0, mc4}, 32'd3);
      idle(3);
      chk("queue_drained", q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
